fir_tdm_multich: RTL



---
 rtl/fir_tdm_multich.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fir_tdm_multich.sv
// fir_tdm_multich: multi-channel FIR filter that time-shares one MAC across all channels.
// Define FIR_OUT_SAT_EN to saturate out_data when O_W is narrower than full precision.
module fir_tdm_multich #(
    parameter int D_W  = 12,
    parameter int C_W  = 16,
    parameter int TAPS = 16,
    parameter int N_CH = 4,
    parameter int O_W  = 32,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int TW   = $clog2(TAPS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_ch,
    input  logic signed [D_W-1:0] in_data,
    input  logic                  coef_we,
    input  logic [TW-1:0]         coef_addr,
    input  logic signed [C_W-1:0] coef_data,
    output logic                  out_valid,
    output logic [CH_W-1:0]       out_ch,
    output logic signed [O_W-1:0] out_data
);

    localparam int P_W = D_W + C_W;
    localparam int A_W = P_W + TW;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [C_W-1:0] coef  [TAPS];
    logic signed [D_W-1:0] dline [N_CH][TAPS];
    logic [TW-1:0]         wptr  [N_CH];

    logic [CH_W-1:0]       ch_q;
    logic [TW-1:0]         base_q;
    logic [TW-1:0]         k_q;
    logic [TW-1:0]         rd_idx;
    logic signed [A_W-1:0] acc_q;
    logic signed [P_W-1:0] prod;
    logic [O_W-1:0]        res;
    logic                  ch_ok;
    logic                  accept;
    logic                  coef_wr;
    logic                  last_tap;

    // Only reachable as false when N_CH is not a power of two.
    assign ch_ok    = 32'(in_ch) < 32'(N_CH);
    assign last_tap = (k_q == TW'(TAPS - 1));
    assign rd_idx   = base_q - k_q;
    assign prod     = P_W'(coef[k_q])
                    * P_W'(dline[ch_q][rd_idx]);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        coef_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = ~reset;
                coef_wr  = coef_we;
                accept   = in_valid;
                if (in_valid && ch_ok) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < TAPS; t++) begin
                coef[t] <= '0;
            end
            for (int c = 0; c < N_CH; c++) begin
                wptr[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    dline[c][t] <= '0;
                end
            end
            ch_q      <= '0;
            base_q    <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            // Coefficient write lands before the MAC reads it.
            if (coef_wr) begin
                coef[coef_addr] <= coef_data;
            end
            if (accept && ch_ok) begin
                dline[in_ch][wptr[in_ch]] <= in_data;
                ch_q   <= in_ch;
                base_q <= wptr[in_ch];
                k_q    <= '0;
                acc_q  <= '0;
            end
            if (state_q == MAC) begin
                acc_q <= acc_q + A_W'(prod);
                k_q   <= k_q + TW'(1);
                if (last_tap) begin
                    wptr[ch_q] <= wptr[ch_q] + TW'(1);
                end
            end
            if (state_q == OUT) begin
                out_valid <= 1'b1;
                out_ch    <= ch_q;
                out_data  <= res;
            end
        end
    end

    generate
        if (O_W >= A_W) begin : g_ext
            assign res = O_W'(acc_q);
        end else begin : g_nar
`ifdef FIR_OUT_SAT_EN
            logic ovf;
            // Overflow when the bits above the output sign are not a sign extension.
            assign ovf = (acc_q[A_W-1:O_W-1] != '0)
                      && (acc_q[A_W-1:O_W-1] != '1);
            assign res = ovf
                ? {acc_q[A_W-1], {(O_W-1){~acc_q[A_W-1]}}}
                : acc_q[O_W-1:0];
`else
            assign res = acc_q[O_W-1:0];
`endif
        end
    endgenerate

endmodule
